// File: rtl/color_matrix_pipe.sv
`timescale 1ns/1ps
// color_matrix_pipe: streaming 3x3 signed colour matrix with per-row offset, rounding and
// output saturation. Three register stages (multiply / sum+offset / round+saturate) with one
// shared advance enable for backpressure. Coefficients are written into a shadow bank. A
// commit copies the shadow bank to the active bank when the next start-of-frame pixel is
// accepted, or as soon as the pipeline is fully idle.
//
// Ports:
//   clock, reset                   rising-edge clock, async active-high reset
//   in_valid/in_ready/in_sof       input handshake and start-of-frame marker
//   iR, iG, iB                     unsigned input components (DSIZE)
//   out_valid/out_ready/out_sof    output handshake and aligned start-of-frame marker
//   oC0, oC1, oC2                  unsigned saturated output components (DSIZE)
//   cfg_we/cfg_addr/cfg_data       shadow write (0-8 M00..M22 row-major, 9-11 OFF0..OFF2)
//   cfg_commit, cfg_pending        commit request and commit-waiting status
//   out_clip, clip_count           only with CMX_CLIP_STAT_EN: per-channel saturation flags
//                                  and a per-frame count of output pixels with any flag set
//
// Optional feature macro: CMX_CLIP_STAT_EN
module color_matrix_pipe #(
  parameter int unsigned DSIZE = 16,
  parameter int unsigned MSIZE = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [DSIZE-1:0] iR,
  input  logic [DSIZE-1:0] iG,
  input  logic [DSIZE-1:0] iB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic [DSIZE-1:0] oC0,
  output logic [DSIZE-1:0] oC1,
  output logic [DSIZE-1:0] oC2,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [MSIZE-1:0] cfg_data,
  input  logic             cfg_commit,
  output logic             cfg_pending
`ifdef CMX_CLIP_STAT_EN
  ,
  output logic [2:0]       out_clip,
  output logic [15:0]      clip_count
`endif
);

  localparam int unsigned FRAC = MSIZE - 2;
  localparam int unsigned PW   = DSIZE + MSIZE + 1;  // product width
  localparam int unsigned AW   = DSIZE + MSIZE + 3;  // accumulator width
  localparam logic signed [MSIZE-1:0] UNITY = MSIZE'(1 << FRAC);
  localparam logic signed [AW-1:0]    HALF  = AW'(1 << (FRAC - 1));

  logic adv, hs_in, idle, swap;

  logic signed [MSIZE-1:0] coef_act [9];
  logic signed [MSIZE-1:0] coef_sh  [9];
  logic signed [MSIZE-1:0] off_act  [3];
  logic signed [MSIZE-1:0] off_sh   [3];
  logic signed [MSIZE-1:0] coef_sel [9];
  logic signed [MSIZE-1:0] off_sel  [3];

  logic [DSIZE-1:0]        pix [3];
  logic signed [PW-1:0]    prod_d [9];
  logic signed [PW-1:0]    prod_q [9];
  logic signed [MSIZE-1:0] s1_off [3];
  logic                    s1_v, s1_sof;

  logic signed [AW-1:0]    acc_d [3];
  logic signed [AW-1:0]    acc_q [3];
  logic                    s2_v, s2_sof;

  logic signed [AW-1:0]    rnd [3];
  logic signed [AW-1:0]    shd [3];
  logic [DSIZE-1:0]        res_d [3];
`ifdef CMX_CLIP_STAT_EN
  logic [2:0]              clip_d;
`endif

  always_comb begin
    adv      = out_ready || !out_valid;
    in_ready = adv;
    hs_in    = in_valid && adv;
    idle     = !in_valid && !s1_v && !s2_v && !out_valid;
    // The sof pixel accepted in the swap cycle already uses the new bank.
    swap     = cfg_pending && ((hs_in && in_sof) || idle);
  end

  // S1: nine products; the selected bank is frozen into the products and offset copy.
  always_comb begin
    pix[0] = iR;
    pix[1] = iG;
    pix[2] = iB;
    for (int k = 0; k < 9; k++) begin
      coef_sel[k] = swap ? coef_sh[k] : coef_act[k];
      prod_d[k]   = signed'(PW'(pix[k % 3])) * PW'(coef_sel[k]);
    end
    for (int k = 0; k < 3; k++) begin
      off_sel[k] = swap ? off_sh[k] : off_act[k];
    end
  end

  // S2: row sums plus offset aligned to the coefficient binary point.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      acc_d[r] = AW'(prod_q[3*r]) + AW'(prod_q[3*r+1]) + AW'(prod_q[3*r+2])
               + (AW'(s1_off[r]) <<< FRAC);
    end
  end

  // S3: round half up, drop fraction, clamp to [0, 2^DSIZE-1].
  always_comb begin
`ifdef CMX_CLIP_STAT_EN
    clip_d = '0;
`endif
    for (int r = 0; r < 3; r++) begin
      rnd[r] = acc_q[r] + HALF;
      shd[r] = rnd[r] >>> FRAC;
      if (shd[r][AW-1]) begin
        res_d[r] = '0;
      end else if (|shd[r][AW-2:DSIZE]) begin
        res_d[r] = '1;
      end else begin
        res_d[r] = shd[r][DSIZE-1:0];
      end
`ifdef CMX_CLIP_STAT_EN
      clip_d[r] = shd[r][AW-1] || (|shd[r][AW-2:DSIZE]);
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 9; k++) begin
        coef_act[k] <= (k % 4 == 0) ? UNITY : '0;
        coef_sh[k]  <= (k % 4 == 0) ? UNITY : '0;
      end
      for (int k = 0; k < 3; k++) begin
        off_act[k] <= '0;
        off_sh[k]  <= '0;
      end
      cfg_pending <= 1'b0;
    end else begin
      if (cfg_we && !cfg_pending) begin
        for (int k = 0; k < 9; k++) begin
          if (cfg_addr == 4'(k)) coef_sh[k] <= cfg_data;
        end
        for (int k = 0; k < 3; k++) begin
          if (cfg_addr == 4'(k + 9)) off_sh[k] <= cfg_data;
        end
      end
      if (swap) begin
        for (int k = 0; k < 9; k++) coef_act[k] <= coef_sh[k];
        for (int k = 0; k < 3; k++) off_act[k] <= off_sh[k];
        cfg_pending <= 1'b0;
      end else if (cfg_commit) begin
        cfg_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_v      <= 1'b0;
      s1_sof    <= 1'b0;
      s2_v      <= 1'b0;
      s2_sof    <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      oC0       <= '0;
      oC1       <= '0;
      oC2       <= '0;
      for (int k = 0; k < 9; k++) prod_q[k] <= '0;
      for (int k = 0; k < 3; k++) begin
        s1_off[k] <= '0;
        acc_q[k]  <= '0;
      end
    end else if (adv) begin
      s1_v      <= in_valid;
      s1_sof    <= in_valid && in_sof;
      for (int k = 0; k < 9; k++) prod_q[k] <= prod_d[k];
      for (int k = 0; k < 3; k++) begin
        s1_off[k] <= off_sel[k];
        acc_q[k]  <= acc_d[k];
      end
      s2_v      <= s1_v;
      s2_sof    <= s1_sof;
      out_valid <= s2_v;
      out_sof   <= s2_sof;
      oC0       <= res_d[0];
      oC1       <= res_d[1];
      oC2       <= res_d[2];
    end
  end

`ifdef CMX_CLIP_STAT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_clip   <= '0;
      clip_count <= '0;
    end else begin
      if (adv) out_clip <= clip_d;
      // A sof pixel restarts the count and contributes to the fresh value.
      if (out_valid && out_ready) begin
        if (out_sof) begin
          clip_count <= {15'd0, |out_clip};
        end else if ((|out_clip) && (clip_count != 16'hFFFF)) begin
          clip_count <= clip_count + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_color_matrix_pipe.sv
`timescale 1ns/1ps
module tb_color_matrix_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_sof;
  logic [15:0] iR, iG, iB;
  logic        out_valid, out_ready, out_sof;
  logic [15:0] oC0, oC1, oC2;
  logic        cfg_we, cfg_commit, cfg_pending;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;
`ifdef CMX_CLIP_STAT_EN
  logic [2:0]  out_clip;
  logic [15:0] clip_count;
`endif

  color_matrix_pipe #(.DSIZE(16), .MSIZE(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .iR(iR), .iG(iG), .iB(iB),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
    .oC0(oC0), .oC1(oC1), .oC2(oC2),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_pending(cfg_pending)
`ifdef CMX_CLIP_STAT_EN
    , .out_clip(out_clip), .clip_count(clip_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int       c0, c1, c2;
    bit       sof;
    bit [2:0] clip;
  } exp_t;

  // Reference model: banks as plain integers, in-flight pixels as an ordered queue.
  int   m_coef_act[9], m_coef_sh[9], m_off_act[3], m_off_sh[3];
  bit   m_pending;
  int   m_cnt;
  exp_t q[$];
  int   n_in = 0, n_out = 0;
  int   log_c0[256], log_c1[256], log_c2[256];
  bit   log_sof[256];
  bit [2:0] log_clip[256];
  int   total = 0, bad = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model_pix(int r, int g, int b, bit sof, bit use_sh);
    exp_t   e;
    longint acc, v;
    int     x[3];
    int     res[3];
    x[0] = r; x[1] = g; x[2] = b;
    for (int row = 0; row < 3; row++) begin
      acc = 0;
      for (int col = 0; col < 3; col++)
        acc += longint'(use_sh ? m_coef_sh[row*3+col] : m_coef_act[row*3+col]) * longint'(x[col]);
      acc += longint'(use_sh ? m_off_sh[row] : m_off_act[row]) * 16384;
      v = (acc + 8192) >>> 14;  // floor division after adding one half
      e.clip[row] = (v < 0) || (v > 65535);
      res[row] = (v < 0) ? 0 : (v > 65535) ? 65535 : int'(v);
    end
    e.c0 = res[0]; e.c1 = res[1]; e.c2 = res[2]; e.sof = sof;
    return e;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 9; k++) begin
      m_coef_act[k] = (k % 4 == 0) ? 16384 : 0;
      m_coef_sh[k]  = m_coef_act[k];
    end
    for (int k = 0; k < 3; k++) begin
      m_off_act[k] = 0;
      m_off_sh[k]  = 0;
    end
    m_pending = 0;
    m_cnt     = 0;
    q.delete();
    n_in = n_out;
  endtask

  // Compare process: one evaluation per cycle at the falling edge, then the model
  // advances by what the coming rising edge will do.
  initial begin
    bit   hs, swap, idle, anyc;
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        m_reset();
        check("reset_out_valid", out_valid, 0);
      end else begin
        check("in_ready_rule", in_ready, out_ready || !out_valid);
        check("cfg_pending", cfg_pending, m_pending);
`ifdef CMX_CLIP_STAT_EN
        check("clip_count", clip_count, m_cnt);
`endif
        if (out_valid) begin
          check("out_valid_has_pixel", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            check("oC0", oC0, q[0].c0);
            check("oC1", oC1, q[0].c1);
            check("oC2", oC2, q[0].c2);
            check("out_sof", out_sof, q[0].sof);
`ifdef CMX_CLIP_STAT_EN
            check("out_clip", out_clip, q[0].clip);
`endif
          end
        end
        idle = (q.size() == 0) && !in_valid;
        hs   = in_valid && in_ready;
        swap = m_pending && ((hs && in_sof) || idle);
        if (hs) begin
          q.push_back(model_pix(int'(iR), int'(iG), int'(iB), in_sof, swap));
          n_in++;
        end
        if (out_valid && out_ready && q.size() > 0) begin
          e = q.pop_front();
          if (n_out < 256) begin
            log_c0[n_out] = int'(oC0); log_c1[n_out] = int'(oC1); log_c2[n_out] = int'(oC2);
            log_sof[n_out] = out_sof;
`ifdef CMX_CLIP_STAT_EN
            log_clip[n_out] = out_clip;
`endif
          end
          n_out++;
          anyc = |e.clip;
          if (e.sof) m_cnt = anyc ? 1 : 0;
          else if (anyc && m_cnt < 65535) m_cnt++;
        end
        if (cfg_we && !m_pending && cfg_addr <= 11) begin
          if (cfg_addr < 9) m_coef_sh[cfg_addr] = int'($signed(cfg_data));
          else m_off_sh[cfg_addr - 9] = int'($signed(cfg_data));
        end
        if (swap) begin
          m_coef_act = m_coef_sh;
          m_off_act  = m_off_sh;
          m_pending  = 0;
        end else if (cfg_commit) begin
          m_pending = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_wr(input int addr, input int data);
    cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_data = 16'(data);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic commit_idle();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    tick();
    check("commit_idle_applied", cfg_pending, 0);
  endtask

  task automatic send(input int r, input int g, input int b, input bit sof);
    in_valid = 1'b1; iR = 16'(r); iG = 16'(g); iB = 16'(b); in_sof = sof;
    tick();
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0; in_sof = 1'b0;
    n = 0;
    while ((q.size() > 0 || out_valid) && n < 60) begin
      tick();
      n++;
    end
    check("drain_empty", q.size() + int'(out_valid), 0);
  endtask

  task automatic chk_log(input string nm, input int idx, input int c0, input int c1, input int c2,
                         input bit sof);
    if (idx >= n_out) begin
      check({nm, "_present"}, n_out, idx + 1);
    end else begin
      check({nm, "_c0"}, log_c0[idx], c0);
      check({nm, "_c1"}, log_c1[idx], c1);
      check({nm, "_c2"}, log_c2[idx], c2);
      check({nm, "_sof"}, log_sof[idx], sof);
    end
  endtask

  initial begin
    int base, lat, idx, c, stall, sof_idx;
    bit acc;
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; iR = '0; iG = '0; iB = '0;
    out_ready = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_oC", {oC0, oC1, oC2}, 0);
    check("rst_cfg_pending", cfg_pending, 0);
    check("rst_in_ready", in_ready, 1);
    tick();

    // Identity after reset, three-cycle latency.
    base = n_in;
    send(100, 200, 300, 1'b1);
    in_valid = 1'b0; in_sof = 1'b0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!out_valid && lat < 10);
    check("latency", lat, 3);
    tick();
    drain();
    chk_log("identity", base, 100, 200, 300, 1'b1);

    // Row 0 = 0.5 each, then rounding of 0.5 up.
    cfg_wr(0, 8192); cfg_wr(1, 8192); cfg_wr(2, 8192);
    commit_idle();
    base = n_in;
    send(100, 200, 300, 1'b1);
    drain();
    chk_log("half_row", base, 300, 200, 300, 1'b1);
    cfg_wr(1, 0); cfg_wr(2, 0);
    commit_idle();
    base = n_in;
    send(1, 0, 0, 1'b1);
    drain();
    chk_log("round", base, 1, 0, 0, 1'b1);

    // Saturation high, low via negative coefficient, low via negative offset.
    cfg_wr(0, 32767); cfg_wr(4, 16'hC000); cfg_wr(11, 16'hFFFB);
    commit_idle();
    base = n_in;
    send(65535, 0, 5, 1'b1);
    send(0, 10, 5, 1'b0);
    send(0, 0, 3, 1'b0);
    drain();
    chk_log("sat_hi", base, 65535, 0, 0, 1'b1);
    chk_log("sat_lo_coef", base + 1, 0, 0, 0, 1'b0);
    chk_log("sat_lo_off", base + 2, 0, 0, 0, 1'b0);
`ifdef CMX_CLIP_STAT_EN
    check("clip_flag0", log_clip[base], 3'b001);
    check("clip_flag1", log_clip[base+1], 3'b010);
    check("clip_flag2", log_clip[base+2], 3'b100);
    check("clip_count_frame", clip_count, 3);
`endif

    // Back to identity; stream 20 pixels with a 5-cycle downstream stall.
    cfg_wr(0, 16384); cfg_wr(4, 16384); cfg_wr(11, 0);
    commit_idle();
    base = n_out;
    idx = 0; c = 0; stall = 0;
    while (idx < 20 && c < 200) begin
      out_ready = !(c >= 8 && c < 13);
      in_valid = 1'b1; in_sof = (idx == 0);
      iR = 16'(idx * 100 + 1); iG = 16'(idx * 100 + 2); iB = 16'(65535 - idx);
      @(negedge clock);
      acc = in_ready;
      if (!acc) stall++;
      @(posedge clock);
      #1;
      if (acc) idx++;
      c++;
    end
    out_ready = 1'b1;
    drain();
    check("bp_stall_cycles", stall, 5);
    check("bp_out_count", n_out - base, 20);

    // Mid-frame commit of zero matrix with OFF0=7; applied at the next sof pixel.
    cfg_wr(0, 0); cfg_wr(4, 0); cfg_wr(8, 0); cfg_wr(9, 7);
    sof_idx = 0; base = n_in;
    for (int i = 0; i < 8; i++) begin
      if (i == 3 || i == 6) check("mid_pending_set", cfg_pending, 1);
      if (i == 7) check("mid_pending_cleared", cfg_pending, 0);
      if (i == 6) sof_idx = n_in;
      cfg_commit = (i == 2);
      cfg_we = (i == 4); cfg_addr = 4'd10; cfg_data = 16'd99;
      send(10 + i, 20 + i, 30 + i, (i == 0 || i == 6));
    end
    cfg_commit = 1'b0; cfg_we = 1'b0;
    drain();
    chk_log("pre_swap", base + 5, 15, 25, 35, 1'b0);
    chk_log("swap_sof", sof_idx, 7, 0, 0, 1'b1);
    chk_log("post_swap", sof_idx + 1, 7, 0, 0, 1'b0);

    // Reset with three pixels in flight and a commit pending.
    cfg_we = 1'b1; cfg_addr = 4'd10; cfg_data = 16'd50; cfg_commit = 1'b1;
    send(1, 2, 3, 1'b0);
    cfg_we = 1'b0; cfg_commit = 1'b0;
    send(4, 5, 6, 1'b0);
    send(7, 8, 9, 1'b0);
    in_valid = 1'b0;
    check("pre_reset_pending", cfg_pending, 1);
    #1 reset = 1'b1;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_pending", cfg_pending, 0);
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) tick();
    base = n_in;
    send(5, 6, 7, 1'b1);
    drain();
    chk_log("post_reset_identity", base, 5, 6, 7, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
